// File: rtl/mux_decode_pkg.sv
// Shared widths and types for the mux/decode unit.
// Also holds the 4-to-16 one-hot decode helper used by the top level.
package mux_decode_pkg;

    localparam int MUX_WIDTH = 16;
    localparam int SEL_WIDTH = 4;
    localparam int DEC_OUT   = 16;

    typedef logic [SEL_WIDTH-1:0] sel_t;
    typedef logic [DEC_OUT-1:0]   onehot_t;

    // Two cascaded 2-to-4 stages: the high pair gates which nibble receives the low-pair one-hot.
    function automatic onehot_t decode_4to16(input logic en, input sel_t idx);
        logic [3:0] lo_hot;
        logic [3:0] hi_hot;
        onehot_t    result;
        lo_hot = 4'b0001 << idx[1:0];
        hi_hot = en ? (4'b0001 << idx[3:2]) : 4'b0000;
        for (int h = 0; h < 4; h++) begin
            result[h*4 +: 4] = hi_hot[h] ? lo_hot : 4'b0000;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux2.sv
// Purely combinational single-bit 2:1 multiplexer.
// Building block for the 2:1 path and the 16:1 tree.
module mux2
    import mux_decode_pkg::*;
(
    input  logic W0,
    input  logic W1,
    input  logic SEL,
    output logic Y
);

    assign Y = SEL ? W1 : W0;

endmodule

// File: rtl/mux_decode_unit.sv
// Registered 2:1 mux, 16:1 mux and 4-to-16 decoder with enable.
// All three paths are independent and have one cycle of latency.
module mux_decode_unit
    import mux_decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m2_w0,
    input  logic                 m2_w1,
    input  logic                 m2_sel,
    input  logic [MUX_WIDTH-1:0] m16_w,
    input  sel_t                 m16_sel,
    input  logic                 dec_en,
    input  sel_t                 dec_w,
    output logic                 m2_y,
    output logic                 m16_y,
    output onehot_t              dec_y
);

    logic    w_m2_next;
    logic    w_lvl1 [8];
    logic    w_lvl2 [4];
    logic    w_lvl3 [2];
    logic    w_m16_next;
    onehot_t w_dec_next;

    logic    r_m2_y;
    logic    r_m16_y;
    onehot_t r_dec_y;

    mux2 u_m2 (
        .W0  (m2_w0),
        .W1  (m2_w1),
        .SEL (m2_sel),
        .Y   (w_m2_next)
    );

    // Tree levels: select bit 0 at the leaves, bit 3 at the root.
    for (genvar i = 0; i < 8; i++) begin : g_leaf
        mux2 u_mux (
            .W0  (m16_w[2*i]),
            .W1  (m16_w[2*i+1]),
            .SEL (m16_sel[0]),
            .Y   (w_lvl1[i])
        );
    end

    for (genvar i = 0; i < 4; i++) begin : g_mid1
        mux2 u_mux (
            .W0  (w_lvl1[2*i]),
            .W1  (w_lvl1[2*i+1]),
            .SEL (m16_sel[1]),
            .Y   (w_lvl2[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_mid2
        mux2 u_mux (
            .W0  (w_lvl2[2*i]),
            .W1  (w_lvl2[2*i+1]),
            .SEL (m16_sel[2]),
            .Y   (w_lvl3[i])
        );
    end

    mux2 u_root (
        .W0  (w_lvl3[0]),
        .W1  (w_lvl3[1]),
        .SEL (m16_sel[3]),
        .Y   (w_m16_next)
    );

    assign w_dec_next = decode_4to16(dec_en, dec_w);

    // Output capture registers, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m2_y  <= 1'b0;
            r_m16_y <= 1'b0;
            r_dec_y <= 16'h0000;
        end else begin
            r_m2_y  <= w_m2_next;
            r_m16_y <= w_m16_next;
            r_dec_y <= w_dec_next;
        end
    end

    assign m2_y  = r_m2_y;
    assign m16_y = r_m16_y;
    assign dec_y = r_dec_y;

endmodule

// File: tb/tb_mux_decode_unit.sv
// Directed plus randomized bench for mux_decode_unit with an arithmetic reference model.
module tb_mux_decode_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m2_w0, m2_w1, m2_sel;
    logic [15:0] m16_w;
    logic [3:0]  m16_sel;
    logic        dec_en;
    logic [3:0]  dec_w;
    logic        m2_y, m16_y;
    logic [15:0] dec_y;

    int vectors    = 0;
    int miscompares = 0;

    logic        e_m2, e_m16;
    logic [15:0] e_dec;

    mux_decode_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m2_w0   (m2_w0),
        .m2_w1   (m2_w1),
        .m2_sel  (m2_sel),
        .m16_w   (m16_w),
        .m16_sel (m16_sel),
        .dec_en  (dec_en),
        .dec_w   (dec_w),
        .m2_y    (m2_y),
        .m16_y   (m16_y),
        .dec_y   (dec_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic definition of each function.
    task automatic predict();
        logic [1:0] pair;
        int         pick;
        pair  = {m2_w1, m2_w0};
        e_m2  = pair[m2_sel];
        pick  = (int'(m16_w) / (2 ** int'(m16_sel))) % 2;
        e_m16 = (pick == 1);
        e_dec = dec_en ? 16'(2 ** int'(dec_w)) : 16'h0000;
    endtask

    task automatic step(input string tag);
        predict();
        @(posedge clk);
        #1;
        chk({tag, ".m2"},  {15'd0, m2_y},  {15'd0, e_m2});
        chk({tag, ".m16"}, {15'd0, m16_y}, {15'd0, e_m16});
        chk({tag, ".dec"}, dec_y, e_dec);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".m2"},  {15'd0, m2_y},  16'h0000);
        chk({tag, ".m16"}, {15'd0, m16_y}, 16'h0000);
        chk({tag, ".dec"}, dec_y, 16'h0000);
    endtask

    task automatic randomize_inputs();
        m2_w0   = 1'($urandom);
        m2_w1   = 1'($urandom);
        m2_sel  = 1'($urandom);
        m16_w   = 16'($urandom);
        m16_sel = 4'($urandom);
        dec_en  = 1'($urandom);
        dec_w   = 4'($urandom);
    endtask

    initial begin
        logic [2:0]  m2_vec [7];
        logic        m2_exp [7];
        logic        held_m2;
        logic [15:0] held_dec;

        m2_vec = '{3'b000, 3'b100, 3'b101, 3'b111, 3'b101, 3'b100, 3'b000};
        m2_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset held with random inputs and a running clock.
        rst_n = 1'b0;
        randomize_inputs();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            randomize_inputs();
        end
        chk_zero("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // 2:1 mux directed table.
        for (int i = 0; i < 7; i++) begin
            {m2_w0, m2_w1, m2_sel} = m2_vec[i];
            step("m2_table");
            chk("m2_table.exp", {15'd0, m2_y}, {15'd0, m2_exp[i]});
        end

        // 16:1 walking one and walking zero.
        for (int i = 0; i < 16; i++) begin
            m16_sel = 4'(i);
            m16_w   = 16'h0001 << i;
            step("m16_walk1");
            chk("m16_walk1.exp", {15'd0, m16_y}, 16'h0001);
            m16_w   = 16'hFFFF - (16'h0001 << i);
            step("m16_walk0");
            chk("m16_walk0.exp", {15'd0, m16_y}, 16'h0000);
        end

        // Decoder disabled then enabled sweeps.
        dec_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dec_w = 4'(i);
            step("dec_off");
        end
        dec_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dec_w = 4'(i);
            step("dec_on");
            if (i == 5)  chk("dec_on.w5",  dec_y, 16'h0020);
            if (i == 15) chk("dec_on.w15", dec_y, 16'h8000);
        end

        // Enable dropping together with an index change.
        dec_en = 1'b0;
        dec_w  = 4'd3;
        step("dec_en_fall");

        // Independence: only m16_sel moves.
        m2_w0 = 1'b1; m2_w1 = 1'b0; m2_sel = 1'b0;
        dec_en = 1'b1; dec_w = 4'd9;
        m16_w = 16'hA5C3;
        step("indep_setup");
        held_m2  = m2_y;
        held_dec = dec_y;
        for (int i = 0; i < 16; i++) begin
            m16_sel = 4'(i);
            step("indep");
            chk("indep.m2_hold",  {15'd0, m2_y}, {15'd0, held_m2});
            chk("indep.dec_hold", dec_y, held_dec);
        end

        // Mid-stream reset between edges must clear without a clock edge.
        m2_w1 = 1'b1; m2_sel = 1'b1; m16_w = 16'hFFFF; dec_en = 1'b1; dec_w = 4'd2;
        step("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("reset_mid");
        @(negedge clk);
        chk_zero("reset_mid_hold");
        rst_n = 1'b1;
        randomize_inputs();
        step("post_release");

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            randomize_inputs();
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
